// File: rtl/jtpang_eeprom93c46_if.sv
// rtl/jtpang_eeprom93c46_if.sv - serial 93C46 pins plus the parallel NVRAM dump port
interface jtpang_eeprom93c46_if #(
  parameter int AW = 6,
  parameter int DW = 16
);
  logic          scs;
  logic          sclk;
  logic          sdi;
  logic          sdo;
  logic [AW-1:0] dump_addr;
  logic          dump_we;
  logic [DW-1:0] dump_din;
  logic [DW-1:0] dump_dout;

  modport master (
    output scs, sclk, sdi, dump_addr, dump_we, dump_din,
    input  sdo, dump_dout
  );

  modport slave (
    input  scs, sclk, sdi, dump_addr, dump_we, dump_din,
    output sdo, dump_dout
  );
endinterface

// File: rtl/jtpang_eeprom93c46.sv
// rtl/jtpang_eeprom93c46.sv - 93C46 x16 serial EEPROM responder with a dump port
// Optional busy time after programming: define JTPANG_EEPROM_BUSY_EN.
module jtpang_eeprom93c46 #(
  parameter int AW          = 6,
  parameter int DW          = 16,
  parameter int BUSY_CYCLES = 4096
) (
  input  logic                  clk,
  input  logic                  rst,
  jtpang_eeprom93c46_if.slave   bus
);
  localparam int WORDS = 1 << AW;
  localparam int CW    = $clog2(DW + AW + 3);
  localparam logic [CW-1:0] CMD_LAST = CW'(AW + 1);
  localparam logic [CW-1:0] DW_LAST  = CW'(DW - 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_CMD   = 3'd1;
  localparam logic [2:0] S_READ  = 3'd2;
  localparam logic [2:0] S_WDATA = 3'd3;
  localparam logic [2:0] S_HOLD  = 3'd4;
  localparam logic [2:0] S_PROG  = 3'd5;

  logic [DW-1:0] mem [0:WORDS-1];
  logic [2:0]    state;
  logic          sclk_l, sdo_r, wen, wall, erase, eral, armed;
  logic [CW-1:0] cnt;
  logic [AW:0]   sr;
  logic [AW-1:0] addr, ptr, idx;
  logic [DW-1:0] wd, rd_sh, dump_q;
  logic          rise, ready, prog_last;
  logic [AW+1:0] cmd;
  logic          ser_we;
  logic [AW-1:0] ser_addr;
  logic [DW-1:0] ser_data;

  assign rise      = bus.sclk & ~sclk_l & bus.scs;
  assign cmd       = {sr, bus.sdi};
  assign rd_sh     = mem[ptr] << cnt;
  assign prog_last = ~(wall | eral) | (&idx);

  always_comb begin
    ser_we   = 1'b0;
    ser_addr = addr;
    ser_data = wd;
    if (state == S_PROG && wen) begin
      ser_we = 1'b1;
      if (wall || eral) ser_addr = idx;
      if (erase || eral) ser_data = '1;
    end
  end

  // The dump side owns the write port on a collision; PROG simply stalls.
  always_ff @(posedge clk) begin
    if (bus.dump_we)  mem[bus.dump_addr] <= bus.dump_din;
    else if (ser_we)  mem[ser_addr]      <= ser_data;
    dump_q <= mem[bus.dump_addr];
  end
  assign bus.dump_dout = dump_q;

`ifdef JTPANG_EEPROM_BUSY_EN
  localparam int BW = $clog2(BUSY_CYCLES + 1);
  logic [BW-1:0] busy;
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      busy <= '0;
    else if (state == S_PROG && wen && !bus.dump_we && prog_last)
      busy <= BW'(BUSY_CYCLES - 1);
    else if (busy != '0)
      busy <= busy - 1'b1;
  end
  assign ready = (busy == '0);
`else
  localparam int unused_busy_cycles = BUSY_CYCLES;
  assign ready = 1'b1;
`endif

  assign bus.sdo = sdo_r & (ready | ~bus.scs);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= S_IDLE;
      sclk_l <= 1'b0;
      sdo_r  <= 1'b1;
      wen    <= 1'b0;
      wall   <= 1'b0;
      erase  <= 1'b0;
      eral   <= 1'b0;
      armed  <= 1'b0;
      cnt    <= '0;
      sr     <= '0;
      addr   <= '0;
      ptr    <= '0;
      idx    <= '0;
      wd     <= '0;
    end else begin
      sclk_l <= bus.sclk;
      if (!bus.scs && state != S_PROG) begin
        // Deselect commits a fully received program command, aborts anything else.
        if ((state == S_WDATA && armed) || (state == S_HOLD && (erase || eral))) begin
          state <= S_PROG;
          idx   <= '0;
        end else begin
          state <= S_IDLE;
        end
        sdo_r <= 1'b1;
      end else begin
        case (state)
          S_IDLE: if (rise && bus.sdi && ready) begin
            state <= S_CMD;
            cnt   <= '0;
            wall  <= 1'b0;
            erase <= 1'b0;
            eral  <= 1'b0;
            armed <= 1'b0;
          end
          S_CMD: if (rise) begin
            sr  <= cmd[AW:0];
            cnt <= cnt + 1'b1;
            if (cnt == CMD_LAST) begin
              addr <= cmd[AW-1:0];
              cnt  <= '0;
              case (cmd[AW+1:AW])
                2'b10: begin
                  state <= S_READ;
                  sdo_r <= 1'b0;
                  ptr   <= cmd[AW-1:0];
                end
                2'b01: state <= S_WDATA;
                2'b11: begin
                  erase <= 1'b1;
                  state <= S_HOLD;
                end
                default: begin
                  state <= S_HOLD;
                  case (cmd[AW-1:AW-2])
                    2'b11: wen <= 1'b1;
                    2'b00: wen <= 1'b0;
                    2'b01: begin
                      wall  <= 1'b1;
                      state <= S_WDATA;
                    end
                    default: eral <= 1'b1;
                  endcase
                end
              endcase
            end
          end
          S_READ: if (rise) begin
            sdo_r <= rd_sh[DW-1];
            if (cnt == DW_LAST) begin
              cnt <= '0;
              ptr <= ptr + 1'b1;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          S_WDATA: if (rise && !armed) begin
            wd  <= {wd[DW-2:0], bus.sdi};
            cnt <= cnt + 1'b1;
            if (cnt == DW_LAST) armed <= 1'b1;
          end
          S_HOLD: ;
          S_PROG: begin
            sdo_r <= 1'b1;
            if (!wen) begin
              state <= S_IDLE;
            end else if (!bus.dump_we) begin
              if (prog_last) state <= S_IDLE;
              else           idx   <= idx + 1'b1;
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_jtpang_eeprom93c46.sv
// tb/tb_jtpang_eeprom93c46.sv - randomized self-checking bench for jtpang_eeprom93c46
module tb_jtpang_eeprom93c46;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;

  jtpang_eeprom93c46_if #(.AW(6), .DW(16)) bus ();

  jtpang_eeprom93c46 #(.AW(6), .DW(16), .BUSY_CYCLES(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  logic [15:0] m [64];
  logic        m_wen = 1'b0;
  logic [15:0] rd_buf [4];
  logic        rd_dummy;

  task automatic sbit(input logic b);
    @(negedge clk); bus.sdi = b; bus.sclk = 1'b0;
    @(negedge clk); bus.sclk = 1'b1;
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic send(input logic [31:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) sbit(v[i]);
  endtask

  task automatic cs_off(input int n);
    @(negedge clk); bus.scs = 1'b0; bus.sclk = 1'b0; bus.sdi = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic op_cmd(input logic [1:0] op, input logic [5:0] a);
    @(negedge clk); bus.scs = 1'b1;
    send({23'd0, 1'b1, op, a}, 9);
  endtask

  task automatic ser_write(input logic [5:0] a, input logic [15:0] d);
    op_cmd(2'b01, a);
    send({16'd0, d}, 16);
    cs_off(24);
    if (m_wen) m[a] = d;
  endtask

  task automatic ser_misc(input logic [5:0] a, input int wait_clks);
    op_cmd(2'b00, a);
    cs_off(wait_clks);
  endtask

  task automatic ser_read(input logic [5:0] a, input int n);
    op_cmd(2'b10, a);
    rd_dummy = bus.sdo;
    for (int w = 0; w < n; w++) begin
      for (int b = 0; b < 16; b++) begin
        sbit(1'b0);
        rd_buf[w] = {rd_buf[w][14:0], bus.sdo};
      end
    end
    cs_off(2);
  endtask

  task automatic dump_wr(input logic [5:0] a, input logic [15:0] d);
    @(negedge clk); bus.dump_we = 1'b1; bus.dump_addr = a; bus.dump_din = d;
    @(negedge clk); bus.dump_we = 1'b0;
    m[a] = d;
  endtask

  task automatic dump_rd(input logic [5:0] a, output logic [15:0] d);
    @(negedge clk); bus.dump_addr = a;
    @(negedge clk); d = bus.dump_dout;
  endtask

  task automatic test_reset();
    bus.scs = 1'b0; bus.sclk = 1'b0; bus.sdi = 1'b0;
    bus.dump_we = 1'b0; bus.dump_addr = '0; bus.dump_din = '0;
    repeat (3) @(negedge clk);
    total++;
    if (bus.sdo !== 1'b1) begin bad++; $display("FAIL reset_sdo: got %b want 1", bus.sdo); end
    rst = 1'b0;
    @(negedge clk); bus.scs = 1'b1;
    @(negedge clk);
    total++;
    if (bus.sdo !== 1'b1) begin bad++; $display("FAIL reset_sdo_cs: got %b want 1", bus.sdo); end
    cs_off(2);
  endtask

  task automatic test_dump_read();
    logic [15:0] d;
    logic [5:0]  a;
    for (int i = 0; i < 64; i++) dump_wr(6'(i), 16'($urandom));
    dump_wr(6'd5, 16'h1234);
    dump_wr(6'd6, 16'hABCD);
    for (int i = 0; i < 6; i++) begin
      a = 6'($urandom_range(0, 63));
      dump_rd(a, d);
      total++;
      if (d !== m[a]) begin bad++; $display("FAIL dump_rd a=%0d: got %h want %h", a, d, m[a]); end
    end
    ser_read(6'd5, 2);
    total++;
    if (rd_dummy !== 1'b0) begin bad++; $display("FAIL read_dummy: got %b want 0", rd_dummy); end
    total++;
    if (rd_buf[0] !== 16'h1234) begin bad++; $display("FAIL read_w5: got %h want 1234", rd_buf[0]); end
    total++;
    if (rd_buf[1] !== 16'hABCD) begin bad++; $display("FAIL read_w6: got %h want abcd", rd_buf[1]); end
    ser_read(6'd63, 2);
    total++;
    if (rd_buf[0] !== m[63] || rd_buf[1] !== m[0]) begin
      bad++; $display("FAIL read_wrap: got %h %h want %h %h", rd_buf[0], rd_buf[1], m[63], m[0]);
    end
  endtask

  task automatic test_write_protect();
    logic [15:0] d, old;
    logic [5:0]  a;
    old = m[3];
    ser_write(6'd3, 16'h5A5A);
    dump_rd(6'd3, d);
    total++;
    if (d !== old) begin bad++; $display("FAIL wp_unchanged: got %h want %h", d, old); end
    ser_misc(6'b110000, 4); m_wen = 1'b1;
    ser_write(6'd3, 16'h5A5A);
    dump_rd(6'd3, d);
    total++;
    if (d !== 16'h5A5A) begin bad++; $display("FAIL ewen_write: got %h want 5a5a", d); end
    for (int i = 0; i < 4; i++) begin
      a = 6'($urandom_range(0, 63));
      ser_write(a, 16'($urandom));
      ser_read(a, 1);
      total++;
      if (rd_buf[0] !== m[a]) begin bad++; $display("FAIL rand_write a=%0d: got %h want %h", a, rd_buf[0], m[a]); end
    end
    a = 6'($urandom_range(0, 63));
    op_cmd(2'b11, a);
    cs_off(24);
    m[a] = 16'hFFFF;
    dump_rd(a, d);
    total++;
    if (d !== 16'hFFFF) begin bad++; $display("FAIL erase a=%0d: got %h want ffff", a, d); end
    ser_misc(6'b000000, 4); m_wen = 1'b0;
    old = m[a];
    ser_write(a, 16'h0F0F);
    dump_rd(a, d);
    total++;
    if (d !== old) begin bad++; $display("FAIL ewds_write: got %h want %h", d, old); end
    ser_misc(6'b110000, 4); m_wen = 1'b1;
  endtask

  task automatic test_eral_wral();
    logic [15:0] d;
    int errs;
    ser_misc(6'b100000, 100);
    for (int i = 0; i < 64; i++) m[i] = 16'hFFFF;
    errs = 0;
    for (int i = 0; i < 64; i++) begin
      dump_rd(6'(i), d);
      if (d !== m[i]) errs++;
    end
    total++;
    if (errs != 0) begin bad++; $display("FAIL eral: %0d words differ from ffff, want 0", errs); end
    op_cmd(2'b00, 6'b010000);
    send(32'h00FF, 16);
    cs_off(100);
    for (int i = 0; i < 64; i++) m[i] = 16'h00FF;
    errs = 0;
    for (int i = 0; i < 64; i++) begin
      dump_rd(6'(i), d);
      if (d !== m[i]) errs++;
    end
    total++;
    if (errs != 0) begin bad++; $display("FAIL wral: %0d words differ from 00ff, want 0", errs); end
    ser_read(6'd62, 3);
    total++;
    if (rd_buf[0] !== 16'h00FF || rd_buf[1] !== 16'h00FF || rd_buf[2] !== 16'h00FF) begin
      bad++; $display("FAIL wral_read: got %h %h %h want 00ff", rd_buf[0], rd_buf[1], rd_buf[2]);
    end
  endtask

  task automatic test_partial_write();
    logic [15:0] d;
    dump_wr(6'd9, 16'($urandom));
    op_cmd(2'b01, 6'd9);
    send(32'h3FF, 10);
    cs_off(24);
    dump_rd(6'd9, d);
    total++;
    if (d !== m[9]) begin bad++; $display("FAIL partial_write: got %h want %h", d, m[9]); end
    ser_read(6'd9, 1);
    total++;
    if (rd_buf[0] !== m[9] || rd_dummy !== 1'b0) begin
      bad++; $display("FAIL partial_read: got %h/%b want %h/0", rd_buf[0], rd_dummy, m[9]);
    end
  endtask

  task automatic test_collision();
    logic [15:0] d, da, db;
    da = 16'($urandom); db = 16'($urandom);
    op_cmd(2'b01, 6'd20);
    send({16'd0, da}, 16);
    @(negedge clk);
    bus.scs = 1'b0; bus.sclk = 1'b0;
    bus.dump_we = 1'b1; bus.dump_addr = 6'd21; bus.dump_din = db;
    repeat (3) @(negedge clk);
    bus.dump_we = 1'b0;
    repeat (24) @(negedge clk);
    m[20] = da; m[21] = db;
    dump_rd(6'd20, d);
    total++;
    if (d !== da) begin bad++; $display("FAIL collide_serial: got %h want %h", d, da); end
    dump_rd(6'd21, d);
    total++;
    if (d !== db) begin bad++; $display("FAIL collide_dump: got %h want %h", d, db); end
  endtask

  task automatic test_reset_mid_read();
    logic [15:0] d, old;
    logic [5:0]  a;
    a = 6'($urandom_range(0, 63));
    op_cmd(2'b10, a);
    send(32'h0, 5);
    @(negedge clk); rst = 1'b1;
    @(negedge clk);
    total++;
    if (bus.sdo !== 1'b1) begin bad++; $display("FAIL rst_mid_sdo: got %b want 1", bus.sdo); end
    bus.scs = 1'b0; bus.sclk = 1'b0;
    @(negedge clk); rst = 1'b0; m_wen = 1'b0;
    @(negedge clk);
    dump_rd(a, d);
    total++;
    if (d !== m[a]) begin bad++; $display("FAIL rst_mem_kept: got %h want %h", d, m[a]); end
    old = m[a];
    ser_write(a, ~old);
    dump_rd(a, d);
    total++;
    if (d !== old) begin bad++; $display("FAIL rst_wen_cleared: got %h want %h", d, old); end
    ser_read(a, 1);
    total++;
    if (rd_buf[0] !== old) begin bad++; $display("FAIL rst_then_read: got %h want %h", rd_buf[0], old); end
  endtask

`ifdef JTPANG_EEPROM_BUSY_EN
  task automatic test_busy();
    logic [15:0] d;
    d = 16'($urandom);
    ser_misc(6'b110000, 4); m_wen = 1'b1;
    op_cmd(2'b01, 6'd40);
    send({16'd0, d}, 16);
    cs_off(2);
    m[40] = d;
    @(negedge clk); bus.scs = 1'b1;
    @(negedge clk);
    total++;
    if (bus.sdo !== 1'b0) begin bad++; $display("FAIL busy_low: got %b want 0", bus.sdo); end
    sbit(1'b1);
    repeat (20) @(negedge clk);
    total++;
    if (bus.sdo !== 1'b1) begin bad++; $display("FAIL busy_ready: got %b want 1", bus.sdo); end
    ser_read(6'd40, 1);
    total++;
    if (rd_buf[0] !== d || rd_dummy !== 1'b0) begin
      bad++; $display("FAIL busy_start_ignored: got %h/%b want %h/0", rd_buf[0], rd_dummy, d);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_dump_read();
    test_write_protect();
    test_eral_wral();
    test_partial_write();
    test_collision();
    test_reset_mid_read();
`ifdef JTPANG_EEPROM_BUSY_EN
    test_busy();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
